// File: rtl/estimador_pkg.sv
// Shared constants and FSM state type for the estimator state-frame serializer.
package estimador_pkg;

  localparam int DATA_W = 32;
  localparam int NWORDS = 3;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/estimador_state_serializer_if.sv
// Frame-in / word-out handshake bundle of the state serializer.
// Both sides are valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; valid must not drop and the payload must stay stable
// until that edge.
interface estimador_state_serializer_if #(
  parameter int DATA_W = estimador_pkg::DATA_W,
  parameter int IDX_W  = estimador_pkg::IDX_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x0;
  logic [DATA_W-1:0] in_x1;
  logic [DATA_W-1:0] in_x2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;

  modport slave (
    input  in_valid, in_x0, in_x1, in_x2, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

  modport master (
    output in_valid, in_x0, in_x1, in_x2, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/estimador_ser_word_mux.sv
// Combinational NWORDS:1 word selector; unused select codes yield zero.
module estimador_ser_word_mux #(
  parameter int DATA_W = estimador_pkg::DATA_W,
  parameter int NWORDS = estimador_pkg::NWORDS,
  parameter int IDX_W  = estimador_pkg::IDX_W
) (
  input  logic [DATA_W-1:0] words [NWORDS],
  input  logic [IDX_W-1:0]  sel,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (sel == IDX_W'(i)) data = words[i];
    end
  end

endmodule

// File: rtl/estimador_state_serializer.sv
// Captures one x0..x2 state frame and streams it out word by word with index,
// pulsing frame_done and counting frames after the last word is accepted.
module estimador_state_serializer #(
  parameter int DATA_W = estimador_pkg::DATA_W,
  parameter int NWORDS = estimador_pkg::NWORDS,
  parameter int IDX_W  = estimador_pkg::IDX_W,
  parameter int CNT_W  = estimador_pkg::CNT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  estimador_state_serializer_if.slave bus,
  output logic                  frame_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt,
  output estimador_pkg::state_t state_dbg
);

  import estimador_pkg::*;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [IDX_W-1:0]  idx_q;
  logic              frame_done_q;
  logic              busy_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic [DATA_W-1:0] word_q   [NWORDS];
  logic [DATA_W-1:0] in_words [NWORDS];
  logic [DATA_W-1:0] sel_data;
  logic              accept;

  // Map the frame input ports onto word slots; slots without a port read zero.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      case (i)
        0:       in_words[i] = bus.in_x0;
        1:       in_words[i] = bus.in_x1;
        2:       in_words[i] = bus.in_x2;
        default: in_words[i] = '0;
      endcase
    end
  end

  assign accept = out_valid_q & bus.out_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
      for (int i = 0; i < NWORDS; i++) word_q[i] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            for (int i = 0; i < NWORDS; i++) word_q[i] <= in_words[i];
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (idx_q == IDX_W'(NWORDS - 1)) begin
              // Last word leaves: DONE cycle carries the pulse and new count.
              idx_q        <= '0;
              out_valid_q  <= 1'b0;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
              state_q      <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          idx_q       <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  estimador_ser_word_mux #(
    .DATA_W (DATA_W),
    .NWORDS (NWORDS),
    .IDX_W  (IDX_W)
  ) u_word_mux (
    .words (word_q),
    .sel   (idx_q),
    .data  (sel_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = sel_data;
  assign bus.out_idx   = idx_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_estimador_state_serializer.sv
// Directed bench for the state serializer: frame table, back-pressure,
// mid-frame reset and a narrow-counter wrap instance.
module tb_estimador_state_serializer;

  import estimador_pkg::*;

  logic clk;
  logic rst_n;

  estimador_state_serializer_if #(.DATA_W(32), .IDX_W(2)) bus_a ();
  estimador_state_serializer_if #(.DATA_W(32), .IDX_W(2)) bus_b ();

  logic        frame_done_a, busy_a, frame_done_b, busy_b;
  logic [15:0] frame_cnt_a;
  logic [1:0]  frame_cnt_b;
  state_t      state_a, state_b;

  estimador_state_serializer #(.DATA_W(32), .NWORDS(3), .IDX_W(2), .CNT_W(16)) dut_a (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .bus        (bus_a),
    .frame_done (frame_done_a),
    .busy       (busy_a),
    .frame_cnt  (frame_cnt_a),
    .state_dbg  (state_a)
  );

  estimador_state_serializer #(.DATA_W(32), .NWORDS(3), .IDX_W(2), .CNT_W(2)) dut_b (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .bus        (bus_b),
    .frame_done (frame_done_b),
    .busy       (busy_b),
    .frame_cnt  (frame_cnt_b),
    .state_dbg  (state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] x0, x1, x2;
    int          stall_idx;
    int          stall_len;
    bit          change_in;
    logic [31:0] e0, e1, e2;
    logic [15:0] exp_cnt;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input frame_vec_t v);
    int k;
    int stall_cnt;
    int guard;
    bus_a.in_x0    = v.x0;
    bus_a.in_x1    = v.x1;
    bus_a.in_x2    = v.x2;
    bus_a.in_valid = 1'b1;
    chk("in_ready_idle", 64'(bus_a.in_ready), 64'd1);
    step();
    bus_a.in_valid = 1'b0;
    exp_q.push_back(v.e0);
    exp_q.push_back(v.e1);
    exp_q.push_back(v.e2);
    if (v.change_in) begin
      bus_a.in_x0 = 32'hDEADBEEF;
      bus_a.in_x1 = 32'hDEADBEEF;
      bus_a.in_x2 = 32'hDEADBEEF;
    end
    k = 0;
    stall_cnt = 0;
    guard = 0;
    while (k < 3 && guard < 64) begin
      bus_a.out_ready = !(k == v.stall_idx && stall_cnt < v.stall_len);
      chk("out_valid", 64'(bus_a.out_valid), 64'd1);
      chk("out_idx", 64'(bus_a.out_idx), 64'(k));
      chk("out_data", 64'(bus_a.out_data), 64'(exp_q[0]));
      chk("in_ready_send", 64'(bus_a.in_ready), 64'd0);
      chk("frame_done_send", 64'(frame_done_a), 64'd0);
      if (bus_a.out_ready) begin
        void'(exp_q.pop_front());
        k++;
      end else begin
        stall_cnt++;
      end
      guard++;
      step();
    end
    chk("words_accepted", 64'(k), 64'd3);
    chk("done_pulse", 64'(frame_done_a), 64'd1);
    chk("done_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("done_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("done_busy", 64'(busy_a), 64'd1);
    chk("frame_cnt", 64'(frame_cnt_a), 64'(v.exp_cnt));
    step();
    chk("idle_done_low", 64'(frame_done_a), 64'd0);
    chk("idle_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("idle_busy", 64'(busy_a), 64'd0);
    chk("idle_state", 64'(state_a), 64'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    frame_vec_t post_rst;
    logic [1:0] wrap_exp[5];
    int done_seen;
    int last_done;
    int cyc;

    vecs[0] = '{32'h3F800000, 32'h40000000, 32'hBF800000, -1, 0, 1'b0,
                32'h3F800000, 32'h40000000, 32'hBF800000, 16'd1};
    vecs[1] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 1, 4, 1'b0,
                32'h3F800000, 32'h40000000, 32'hBF800000, 16'd2};
    vecs[2] = '{32'h11111111, 32'h22222222, 32'h33333333, 0, 2, 1'b1,
                32'h11111111, 32'h22222222, 32'h33333333, 16'd3};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 2, 1, 1'b1,
                32'hFFFFFFFF, 32'h00000000, 32'h80000000, 16'd4};
    post_rst = '{32'h01234567, 32'h89ABCDEF, 32'h7F800000, 1, 1, 1'b0,
                 32'h01234567, 32'h89ABCDEF, 32'h7F800000, 16'd1};
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;

    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_a.in_x0 = '0; bus_a.in_x1 = '0; bus_a.in_x2 = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    bus_b.in_x0 = '0; bus_b.in_x1 = '0; bus_b.in_x2 = '0;
    repeat (3) step();

    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus_a.out_data), 64'd0);
    chk("rst_out_idx", 64'(bus_a.out_idx), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt_a), 64'd0);
    chk("rst_frame_done", 64'(frame_done_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_state", 64'(state_a), 64'(IDLE));
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("idle_out_valid", 64'(bus_a.out_valid), 64'd0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset while the second word is being held under back-pressure.
    bus_a.in_x0 = 32'hAAAA0000;
    bus_a.in_x1 = 32'hBBBB1111;
    bus_a.in_x2 = 32'hCCCC2222;
    bus_a.in_valid = 1'b1;
    bus_a.out_ready = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
    step();
    bus_a.out_ready = 1'b0;
    chk("mid_idx1", 64'(bus_a.out_idx), 64'd1);
    chk("mid_data1", 64'(bus_a.out_data), 64'hBBBB1111);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt_a), 64'd0);
    chk("mid_rst_idx", 64'(bus_a.out_idx), 64'd0);
    step();
    step();
    chk("mid_rst_no_done", 64'(frame_done_a), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_no_done", 64'(frame_done_a), 64'd0);
    chk("post_rst_frame_cnt", 64'(frame_cnt_a), 64'd0);
    exp_q.delete();
    run_frame(post_rst);

    // Narrow counter: continuous frames, 2-bit count wraps.
    bus_b.in_x0 = 32'h00000001;
    bus_b.in_x1 = 32'h00000002;
    bus_b.in_x2 = 32'h00000003;
    bus_b.in_valid = 1'b1;
    bus_b.out_ready = 1'b1;
    done_seen = 0;
    last_done = 0;
    cyc = 0;
    while (done_seen < 5 && cyc < 200) begin
      if (frame_done_b) begin
        chk("wrap_cnt", 64'(frame_cnt_b), 64'(wrap_exp[done_seen]));
        if (done_seen > 0) chk("frame_period", 64'(cyc - last_done), 64'd5);
        last_done = cyc;
        done_seen++;
      end
      step();
      cyc++;
    end
    chk("wrap_frames", 64'(done_seen), 64'd5);
    bus_b.in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
